// File: rtl/uart_rx_unit.sv
// UART receiver: 16x oversampled 8-bit frames with optional odd/even parity and one stop bit.
// Reports each byte with a one-cycle strobe plus parity and framing error flags.
module uart_rx_unit #(
  parameter int CLK_HZ = 50_000_000,
  parameter int OVS    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_in,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       stop_error,
  output logic       active_flag,
  output logic       done_flag
);

  localparam int D0 = CLK_HZ / (2400 * OVS);
  localparam int D1 = CLK_HZ / (4800 * OVS);
  localparam int D2 = CLK_HZ / (9600 * OVS);
  localparam int D3 = CLK_HZ / (19200 * OVS);
  localparam int DW = (D0 > 1) ? $clog2(D0) : 1;
  localparam int OW = $clog2(OVS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, rx_s_q, armed_q;
  logic [DW-1:0]   tick_cnt_q;
  logic [OW-1:0]   os_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic [1:0]      baud_q, parity_q;
  logic            par_err_q, stop_bad_q;
  logic [7:0]      data_out_q, data_out_d;
  logic            data_valid_q, data_valid_d;
  logic            parity_error_q, parity_error_d;
  logic            stop_error_q, stop_error_d;
  logic            active_q, active_d;
  logic            done_q, done_d;
  logic [DW-1:0]   div_m1_s;
  logic            tick_s, samp_s, start_s, par_en_s;

  always_comb begin
    div_m1_s = DW'(D3 - 1);
    case (baud_q)
      2'b00:   div_m1_s = DW'(D0 - 1);
      2'b01:   div_m1_s = DW'(D1 - 1);
      2'b10:   div_m1_s = DW'(D2 - 1);
      default: div_m1_s = DW'(D3 - 1);
    endcase
  end

  assign tick_s   = (tick_cnt_q == div_m1_s);
  // The start bit is probed at half a bit, every later bit one full bit after the previous probe.
  assign samp_s   = tick_s && ((state_q == S_START) ? (os_cnt_q == OW'(OVS / 2 - 1))
                                                    : (os_cnt_q == OW'(OVS - 1)));
  assign start_s  = (state_q == S_IDLE) && armed_q && !rx_s_q;
  assign par_en_s = (parity_q == 2'b01) || (parity_q == 2'b10);

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_s) state_d = S_START; else state_d = S_IDLE;
      S_START:  if (samp_s) state_d = rx_s_q ? S_IDLE : S_DATA; else state_d = S_START;
      S_DATA:   if (samp_s && (bit_idx_q == 3'd7)) state_d = par_en_s ? S_PARITY : S_STOP;
                else state_d = S_DATA;
      S_PARITY: if (samp_s) state_d = S_STOP; else state_d = S_PARITY;
      S_STOP:   if (samp_s) state_d = S_DONE; else state_d = S_STOP;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs
  always_comb begin
    data_out_d     = data_out_q;
    data_valid_d   = 1'b0;
    parity_error_d = parity_error_q;
    stop_error_d   = stop_error_q;
    active_d       = active_q;
    done_d         = done_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          active_d = 1'b1;
          done_d   = 1'b0;
        end else begin
          active_d = active_q;
        end
      end
      S_START: begin
        if (samp_s && rx_s_q) active_d = 1'b0; else active_d = active_q;
      end
      S_DONE: begin
        data_out_d     = shift_q;
        data_valid_d   = 1'b1;
        parity_error_d = par_err_q;
        stop_error_d   = stop_bad_q;
        active_d       = 1'b0;
        done_d         = 1'b1;
      end
      default: data_valid_d = 1'b0;
    endcase
  end

  // Synchroniser, baud/oversample counters, shift register and per-frame error capture
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      armed_q    <= 1'b0;
      tick_cnt_q <= '0;
      os_cnt_q   <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      baud_q     <= 2'b00;
      parity_q   <= 2'b00;
      par_err_q  <= 1'b0;
      stop_bad_q <= 1'b0;
    end else begin
      sync1_q <= rx_in;
      rx_s_q  <= sync1_q;
      if (start_s) armed_q <= 1'b0;
      else if (rx_s_q) armed_q <= 1'b1;
      if (start_s) begin
        tick_cnt_q <= '0;
        os_cnt_q   <= '0;
        bit_idx_q  <= 3'd0;
        baud_q     <= baud_rate;
        parity_q   <= parity_type;
        par_err_q  <= 1'b0;
        stop_bad_q <= 1'b0;
      end else if ((state_q != S_IDLE) && (state_q != S_DONE)) begin
        tick_cnt_q <= tick_s ? '0 : tick_cnt_q + DW'(1);
        if (tick_s) os_cnt_q <= samp_s ? '0 : os_cnt_q + OW'(1);
        if (samp_s) begin
          case (state_q)
            S_DATA: begin
              shift_q   <= {rx_s_q, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
            end
            S_PARITY: par_err_q <= (parity_q == 2'b01) ? ((^shift_q) == rx_s_q)
                                                       : ((^shift_q) != rx_s_q);
            S_STOP:   stop_bad_q <= ~rx_s_q;
            default:  stop_bad_q <= stop_bad_q;
          endcase
        end
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out_q     <= 8'h00;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
      active_q       <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
      active_q       <= active_d;
      done_q         <= done_d;
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign parity_error = parity_error_q;
  assign stop_error   = stop_error_q;
  assign active_flag  = active_q;
  assign done_flag    = done_q;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Bench for uart_rx_unit: table of frames plus hand-written glitch, break, back-to-back and reset runs.
// Expected bytes/flags go to a scoreboard queue when a frame is driven and are checked on each strobe.
module tb_uart_rx_unit;

  localparam int CLK_HZ = 614_400;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [1:0] parity_type;
  logic [1:0] baud_rate;
  logic [7:0] data_out;
  logic       data_valid, parity_error, stop_error, active_flag, done_flag;

  always #5 clock = ~clock;

  uart_rx_unit #(.CLK_HZ(CLK_HZ), .OVS(16)) dut (
    .clock(clock), .reset(reset), .rx_in(rx_in), .parity_type(parity_type),
    .baud_rate(baud_rate), .data_out(data_out), .data_valid(data_valid),
    .parity_error(parity_error), .stop_error(stop_error),
    .active_flag(active_flag), .done_flag(done_flag)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       serr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] par;
    logic [1:0] baud;
    logic       bad_par;
    logic       stop_bit;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_serr;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected frame
  always @(negedge clock) begin
    if (!reset && data_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got data %0h with no frame expected", data_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({data_out, parity_error, stop_error, active_flag, done_flag} !==
            {e.data, e.perr, e.serr, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL strobe: got data=%0h perr=%b serr=%b act=%b done=%b expected data=%0h perr=%b serr=%b act=0 done=1",
                   data_out, parity_error, stop_error, active_flag, done_flag, e.data, e.perr, e.serr);
        end
      end
    end
  end

  function automatic int bit_clks(input logic [1:0] b);
    int rate;
    case (b)
      2'b00:   rate = 2400;
      2'b01:   rate = 4800;
      2'b10:   rate = 9600;
      default: rate = 19200;
    endcase
    return (CLK_HZ / (rate * 16)) * 16;
  endfunction

  task automatic drive(input logic v, input int n);
    rx_in = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic se);
    exp_t e;
    e.data = d; e.perr = pe; e.serr = se;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] par, input logic [1:0] baud,
                            input logic bad_par, input logic stop_bit);
    int   n;
    logic pbit;
    n = bit_clks(baud);
    baud_rate   = baud;
    parity_type = par;
    pbit = (par == 2'b01) ? ~(^d) : (^d);
    if (bad_par) pbit = ~pbit;
    drive(1'b0, n);
    for (int i = 0; i < 8; i++) drive(d[i], n);
    if ((par == 2'b01) || (par == 2'b10)) drive(pbit, n);
    drive(stop_bit, n);
    rx_in = 1'b1;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'hA5, 2'b00, 2'b10, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h37, 2'b01, 2'b10, 1'b0, 1'b1, 8'h37, 1'b0, 1'b0};
    vecs[2] = '{8'h37, 2'b01, 2'b10, 1'b1, 1'b1, 8'h37, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 2'b10, 2'b00, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[4] = '{8'hC3, 2'b10, 2'b01, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};
    vecs[5] = '{8'h81, 2'b00, 2'b11, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};
    vecs[6] = '{8'h5A, 2'b11, 2'b01, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 2'b01, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

    reset = 1'b1; rx_in = 1'b1; parity_type = 2'b00; baud_rate = 2'b10;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_outputs", {24'h0, data_out}, 32'h0);
    check("reset_flags", {data_valid, parity_error, stop_error, active_flag, done_flag}, 32'h0);
    repeat (20) @(negedge clock);

    // Table of frames across baud rates, parity modes and error cases
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_serr);
      send_frame(vecs[i].data, vecs[i].par, vecs[i].baud, vecs[i].bad_par, vecs[i].stop_bit);
      repeat (2 * bit_clks(vecs[i].baud)) @(negedge clock);
      check("table_strobe_seen", exp_q.size(), 32'd0);
    end
    check("done_after_frames", {31'h0, done_flag}, 32'd1);

    // Glitch on the line: start rejected, next frame clean
    baud_rate = 2'b10; parity_type = 2'b00;
    rx_in = 1'b0;
    repeat (10) @(negedge clock);
    check("glitch_active", {31'h0, active_flag}, 32'd1);
    repeat (10) @(negedge clock);
    rx_in = 1'b1;
    repeat (60) @(negedge clock);
    check("glitch_active_cleared", {31'h0, active_flag}, 32'd0);
    check("glitch_done_cleared", {31'h0, done_flag}, 32'd0);
    push(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 2'b00, 2'b10, 1'b0, 1'b1);
    repeat (128) @(negedge clock);
    check("after_glitch_strobe", exp_q.size(), 32'd0);

    // Break: line held low for 30 bit times
    push(8'h00, 1'b0, 1'b1);
    rx_in = 1'b0;
    repeat (30 * 64) @(negedge clock);
    check("break_no_restart", {31'h0, active_flag}, 32'd0);
    check("break_done", {31'h0, done_flag}, 32'd1);
    check("break_one_strobe", exp_q.size(), 32'd0);
    rx_in = 1'b1;
    repeat (128) @(negedge clock);
    push(8'hC4, 1'b0, 1'b0);
    send_frame(8'hC4, 2'b00, 2'b10, 1'b0, 1'b1);
    repeat (128) @(negedge clock);
    check("after_break_strobe", exp_q.size(), 32'd0);

    // Back-to-back 8E1 frames at 19200 with no idle gap
    push(8'hFF, 1'b0, 1'b0);
    push(8'h00, 1'b0, 1'b0);
    send_frame(8'hFF, 2'b10, 2'b11, 1'b0, 1'b1);
    send_frame(8'h00, 2'b10, 2'b11, 1'b0, 1'b1);
    repeat (64) @(negedge clock);
    check("b2b_strobes", exp_q.size(), 32'd0);

    // Reset during bit 4: no strobe, outputs cleared
    baud_rate = 2'b10; parity_type = 2'b00;
    drive(1'b0, 64);
    for (int i = 0; i < 4; i++) drive(i[0], 64);
    drive(1'b1, 32);
    check("midframe_active", {31'h0, active_flag}, 32'd1);
    reset = 1'b1; rx_in = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset_outputs", {23'h0, data_out, data_valid},
          32'h0);
    check("midreset_flags", {parity_error, stop_error, active_flag, done_flag}, 32'h0);
    repeat (1000) @(negedge clock);
    check("midreset_no_strobe", exp_q.size(), 32'd0);
    check("midreset_idle", {active_flag, done_flag}, 32'h0);

    // Baud and parity inputs changed mid-frame are ignored
    push(8'h96, 1'b0, 1'b0);
    baud_rate = 2'b10; parity_type = 2'b00;
    drive(1'b0, 64);
    for (int i = 0; i < 4; i++) drive(((i == 1) || (i == 2)), 64);
    baud_rate = 2'b00; parity_type = 2'b01;
    for (int i = 4; i < 8; i++) drive(((i == 4) || (i == 7)), 64);
    drive(1'b1, 64);
    repeat (128) @(negedge clock);
    check("baud_change_strobe", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
